// File: rtl/song_sequencer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Package : song_sequencer_pkg                                       |
// | Purpose : Shared types for the song sequencer: song ROM entry      |
// |           layout, FSM state encoding, note vector type and the     |
// |           entry-field clean-up helpers.                            |
// | Ports   : none (package)                                           |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
package song_sequencer_pkg;

   // One bit per note, bit0 = do.
   typedef logic [6:0] Notes;

   // 16-bit song ROM word.
   typedef struct packed {
      logic       end_mark;
      logic [1:0] octave;
      Notes       notes;
      logic [5:0] dur;
   } SongEntry;

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_WAIT  = 3'd2,
      ST_PLAY  = 3'd3,
      ST_GAP   = 3'd4
   } SeqState;

   localparam int DUR_W = 6;

   // Octave code 3 is undefined on the note path; fold it onto mid.
   function automatic logic [1:0] fix_octave(input logic [1:0] oct);
      return (oct == 2'd3) ? 2'd1 : oct;
   endfunction

   // A zero duration would never expire; play it for one tick.
   function automatic logic [DUR_W-1:0] fix_dur(input logic [DUR_W-1:0] dur);
      return (dur == '0) ? DUR_W'(1) : dur;
   endfunction

endpackage
`default_nettype wire

// File: rtl/song_sequencer_tick_prescaler.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tick_prescaler                                           |
// | Purpose : Divides clk into a one-cycle tempo tick every            |
// |           TICK_CYCLES enabled cycles.                              |
// | Ports   : clk       in  system clock                               |
// |           sys_rst_n in  synchronous active-low reset               |
// |           en        in  count enable (count holds when low)        |
// |           clr       in  restart the count from zero                |
// |           tick      out high on the enabled terminal-count cycle   |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tick_prescaler #(
   parameter int TICK_CYCLES = 1_562_500
) (
   input  logic clk,
   input  logic sys_rst_n,
   input  logic en,
   input  logic clr,
   output logic tick
);

   localparam int               CNT_W = $clog2(TICK_CYCLES);
   localparam logic [CNT_W-1:0] TERM  = CNT_W'(TICK_CYCLES - 1);
   localparam logic [CNT_W-1:0] ONE   = CNT_W'(1);

   logic [CNT_W-1:0] count;

   // Tick is decoded from the count register so the FSM sees it in the
   // same cycle the count hits terminal; it only fires while enabled.
   assign tick = en && (count == TERM);

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         count <= '0;
      end else if (clr || tick) begin
         count <= '0;
      end else if (en) begin
         count <= count + ONE;
      end
   end

endmodule
`default_nettype wire

// File: rtl/song_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : song_sequencer                                           |
// | Purpose : Autoplay controller. Fetches song entries from a         |
// |           synchronous ROM, plays each note for its duration in     |
// |           tempo ticks, then inserts an articulation rest.          |
// | Ports   : clk, sys_rst_n       clock, sync active-low reset        |
// |           start, stop, pause   playback control                    |
// |           song_base            first entry address (on start)      |
// |           mem_rd/mem_addr      ROM read strobe / address           |
// |           mem_data             ROM word, one cycle after mem_rd    |
// |           notes/octave         registered note word                |
// |           note_valid           note word is to be sounded          |
// |           step_idx             entry offset from song_base         |
// |           busy/done            activity flag / end-of-song pulse   |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module song_sequencer
   import song_sequencer_pkg::*;
#(
   parameter int ADDR_W      = 10,
   parameter int TICK_CYCLES = 1_562_500,
   parameter int GAP_TICKS   = 2
) (
   input  logic              clk,
   input  logic              sys_rst_n,
   input  logic              start,
   input  logic              stop,
   input  logic              pause,
   input  logic [ADDR_W-1:0] song_base,
   output logic              mem_rd,
   output logic [ADDR_W-1:0] mem_addr,
   input  logic [15:0]       mem_data,
   output logic [6:0]        notes,
   output logic [1:0]        octave,
   output logic              note_valid,
   output logic [ADDR_W-1:0] step_idx,
   output logic              busy,
   output logic              done
);

   localparam logic [DUR_W-1:0]  DCNT_ONE = DUR_W'(1);
   localparam logic [DUR_W-1:0]  GAP_LOAD = DUR_W'(GAP_TICKS);
   localparam logic [ADDR_W-1:0] ADDR_ONE = ADDR_W'(1);

   SeqState           state, state_n;
   logic [ADDR_W-1:0] addr, addr_n, step_n, maddr_n;
   logic [DUR_W-1:0]  dcnt, dcnt_n;
   Notes              ent_notes, ent_notes_n, notes_n;
   logic [1:0]        ent_oct, ent_oct_n, octave_n;
   logic              rd_n, done_n, valid_n, busy_n;
   logic              pre_clr, pre_en, tick, advance;
   SongEntry          word;

   assign word   = mem_data;
   assign pre_en = ((state == ST_PLAY) || (state == ST_GAP)) && !pause;

   tick_prescaler #(
      .TICK_CYCLES (TICK_CYCLES)
   ) u_prescaler (
      .clk       (clk),
      .sys_rst_n (sys_rst_n),
      .en        (pre_en),
      .clr       (pre_clr),
      .tick      (tick)
   );

   always_comb begin
      state_n     = state;
      addr_n      = addr;
      step_n      = step_idx;
      dcnt_n      = dcnt;
      ent_notes_n = ent_notes;
      ent_oct_n   = ent_oct;
      maddr_n     = mem_addr;
      rd_n        = 1'b0;
      done_n      = 1'b0;
      pre_clr     = 1'b0;
      advance     = 1'b0;

      if (stop) begin
         state_n = ST_IDLE;
      end else if (start) begin
         // Restart from any state; a ROM word still in flight is dropped
         // because WAIT is left without latching it.
         state_n = ST_FETCH;
         addr_n  = song_base;
         step_n  = '0;
         maddr_n = song_base;
         rd_n    = 1'b1;
         pre_clr = 1'b1;
      end else begin
         case (state)
            ST_FETCH: state_n = ST_WAIT;
            ST_WAIT: begin
               ent_notes_n = word.notes;
               ent_oct_n   = fix_octave(word.octave);
               if (word.end_mark) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end else begin
                  dcnt_n  = fix_dur(word.dur);
                  pre_clr = 1'b1;
                  state_n = ST_PLAY;
               end
            end
            ST_PLAY: begin
               if (tick) begin
                  dcnt_n = dcnt - DCNT_ONE;
                  if (dcnt == DCNT_ONE) begin
                     if (GAP_TICKS > 0) begin
                        dcnt_n  = GAP_LOAD;
                        pre_clr = 1'b1;
                        state_n = ST_GAP;
                     end else begin
                        advance = 1'b1;
                     end
                  end
               end
            end
            ST_GAP: begin
               if (tick) begin
                  dcnt_n = dcnt - DCNT_ONE;
                  if (dcnt == DCNT_ONE) begin
                     advance = 1'b1;
                  end
               end
            end
            default: ;
         endcase

         if (advance) begin
            // No wrap past the top of the ROM: the last address ends the song.
            if (&addr) begin
               state_n = ST_IDLE;
               done_n  = 1'b1;
            end else begin
               addr_n  = addr + ADDR_ONE;
               step_n  = step_idx + ADDR_ONE;
               maddr_n = addr + ADDR_ONE;
               rd_n    = 1'b1;
               state_n = ST_FETCH;
            end
         end
      end

      // Outputs are registered from the next state so they line up with it.
      notes_n  = (state_n == ST_PLAY) ? ent_notes_n : '0;
      octave_n = ((state_n == ST_PLAY) || (state_n == ST_GAP)) ? ent_oct_n : 2'd0;
      valid_n  = (state_n == ST_PLAY) && !pause && (ent_notes_n != '0);
      busy_n   = (state_n != ST_IDLE);
   end

   always_ff @(posedge clk) begin
      if (!sys_rst_n) begin
         state      <= ST_IDLE;
         addr       <= '0;
         dcnt       <= '0;
         ent_notes  <= '0;
         ent_oct    <= '0;
         mem_rd     <= 1'b0;
         mem_addr   <= '0;
         notes      <= '0;
         octave     <= '0;
         note_valid <= 1'b0;
         step_idx   <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
      end else begin
         state      <= state_n;
         addr       <= addr_n;
         dcnt       <= dcnt_n;
         ent_notes  <= ent_notes_n;
         ent_oct    <= ent_oct_n;
         mem_rd     <= rd_n;
         mem_addr   <= maddr_n;
         notes      <= notes_n;
         octave     <= octave_n;
         note_valid <= valid_n;
         step_idx   <= step_n;
         busy       <= busy_n;
         done       <= done_n;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_song_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------+
// | Module  : tb_song_sequencer                                        |
// | Purpose : Scoreboard bench for song_sequencer with a synchronous   |
// |           ROM model (TICK_CYCLES = 4, GAP_TICKS = 1).              |
// | Ports   : none                                                     |
// | Rev     : 1.0  initial release                                     |
// +--------------------------------------------------------------------+
module tb_song_sequencer;

   localparam int EV_RD   = 0;  // a = address, b = step_idx
   localparam int EV_NOTE = 1;  // t = first valid cycle, a = notes, b = octave, c = length
   localparam int EV_IDLE = 2;  // busy fell; c = done in that cycle

   typedef struct {
      int kind;
      int t;
      int a;
      int b;
      int c;
   } evt_t;

   logic        clk = 1'b0;
   logic        sys_rst_n = 1'b0;
   logic        start = 1'b0;
   logic        stop = 1'b0;
   logic        pause = 1'b0;
   logic [9:0]  song_base = '0;
   logic        mem_rd;
   logic [9:0]  mem_addr;
   logic [15:0] mem_data = '0;
   logic [6:0]  notes;
   logic [1:0]  octave;
   logic        note_valid;
   logic [9:0]  step_idx;
   logic        busy;
   logic        done;

   logic [15:0] rom [0:1023];
   evt_t        exp_q[$];
   int          cyc = 0;
   int          checks = 0;
   int          errors = 0;

   bit          pv = 1'b0;
   bit          pb = 1'b0;
   int          seg_t, seg_len;
   int          seg_n, seg_o;
   bit          seg_ok;

   song_sequencer #(
      .ADDR_W      (10),
      .TICK_CYCLES (4),
      .GAP_TICKS   (1)
   ) dut (
      .clk        (clk),
      .sys_rst_n  (sys_rst_n),
      .start      (start),
      .stop       (stop),
      .pause      (pause),
      .song_base  (song_base),
      .mem_rd     (mem_rd),
      .mem_addr   (mem_addr),
      .mem_data   (mem_data),
      .notes      (notes),
      .octave     (octave),
      .note_valid (note_valid),
      .step_idx   (step_idx),
      .busy       (busy),
      .done       (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (mem_rd) mem_data <= rom[mem_addr];
   end

   function automatic logic [15:0] ent(input int e, input int oct, input int n, input int dur);
      logic [15:0] w;
      w = {e[0], oct[1:0], n[6:0], dur[5:0]};
      return w;
   endfunction

   function automatic string kname(input int k);
      case (k)
         EV_RD:   return "read";
         EV_NOTE: return "note";
         default: return "idle";
      endcase
   endfunction

   task automatic push(input int k, input int t, input int a, input int b, input int c);
      evt_t e;
      e.kind = k; e.t = t; e.a = a; e.b = b; e.c = c;
      exp_q.push_back(e);
   endtask

   task automatic check_evt(input int k, input int t, input int a, input int b, input int c);
      evt_t e;
      checks++;
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL unexpected %s event: got t=%0d a=%0h b=%0d c=%0d, required none",
                  kname(k), t, a, b, c);
      end else begin
         e = exp_q.pop_front();
         if (e.kind != k || e.t != t || e.a != a || e.b != b || e.c != c) begin
            errors++;
            $display("FAIL %s event: got %s t=%0d a=%0h b=%0d c=%0d, required %s t=%0d a=%0h b=%0d c=%0d",
                     kname(e.kind), kname(k), t, a, b, c, kname(e.kind), e.t, e.a, e.b, e.c);
         end
      end
   endtask

   // Monitor: turns DUT activity into events and scores them in order.
   always @(negedge clk) begin
      if (note_valid && !pv) begin
         seg_t = cyc; seg_n = int'(notes); seg_o = int'(octave); seg_len = 0; seg_ok = 1'b1;
      end
      if (note_valid) begin
         seg_len++;
         if (int'(notes) != seg_n || int'(octave) != seg_o) seg_ok = 1'b0;
      end
      if (!note_valid && pv) check_evt(EV_NOTE, seg_t, seg_ok ? seg_n : 999, seg_o, seg_len);
      if (mem_rd === 1'b1) check_evt(EV_RD, cyc, int'(mem_addr), int'(step_idx), 0);
      if (busy === 1'b0 && pb) check_evt(EV_IDLE, cyc, 0, 0, int'(done));
      if (done === 1'b1 && !(busy === 1'b0 && pb)) begin
         checks++;
         errors++;
         $display("FAIL done pulse: got done=1 at cycle %0d with busy=%0b, required done only as busy falls", cyc, busy);
      end
      pv = note_valid;
      pb = busy;
   end

   task automatic goto_cycle(input int c);
      while (cyc < c) begin
         @(posedge clk); #1;
      end
   endtask

   task automatic do_start(input logic [9:0] base, output int t0);
      @(posedge clk); #1;
      song_base = base;
      start = 1'b1;
      t0 = cyc;
      @(posedge clk); #1;
      start = 1'b0;
   endtask

   task automatic drain(input string name, input int budget);
      int n;
      n = 0;
      while (exp_q.size() != 0 && n < budget) begin
         @(posedge clk); #1;
         n++;
      end
      if (exp_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL %s timeout: got %0d events pending, required 0", name, exp_q.size());
         exp_q.delete();
      end
      repeat (12) @(posedge clk);
      #1;
   endtask

   task automatic check_zero(input string name);
      logic [33:0] got;
      got = {mem_rd, mem_addr, notes, octave, note_valid, step_idx, busy, done};
      checks++;
      if (got != '0) begin
         errors++;
         $display("FAIL %s: got outputs %h, required 0", name, got);
      end
   endtask

   task automatic push_basic(input int t);
      push(EV_RD,   t + 1,  'h010, 0, 0);
      push(EV_NOTE, t + 3,  1, 1, 8);
      push(EV_RD,   t + 15, 'h011, 1, 0);
      push(EV_NOTE, t + 17, 2, 2, 4);
      push(EV_RD,   t + 25, 'h012, 2, 0);
      push(EV_IDLE, t + 27, 0, 0, 1);
   endtask

   initial begin
      int t0;
      for (int i = 0; i < 1024; i++) rom[i] = '0;
      rom[10'h000] = ent(0, 1, 7'b0001000, 3);
      rom[10'h010] = ent(0, 1, 7'b0000001, 2);
      rom[10'h011] = ent(0, 2, 7'b0000010, 1);
      rom[10'h012] = ent(1, 0, 0, 0);
      rom[10'h020] = ent(0, 1, 0, 0);
      rom[10'h021] = ent(0, 3, 7'b0000100, 1);
      rom[10'h022] = ent(1, 0, 0, 0);
      rom[10'h3FF] = ent(0, 0, 7'b1000000, 1);

      repeat (3) @(posedge clk);
      #1;
      check_zero("reset state");
      sys_rst_n = 1'b1;
      repeat (2) @(posedge clk);

      // Basic playback
      do_start(10'h010, t0);
      push_basic(t0);
      drain("basic", 200);

      // Pause for 10 cycles mid-note
      do_start(10'h010, t0);
      push(EV_RD,   t0 + 1,  'h010, 0, 0);
      push(EV_NOTE, t0 + 3,  1, 1, 3);
      push(EV_NOTE, t0 + 16, 1, 1, 5);
      push(EV_RD,   t0 + 25, 'h011, 1, 0);
      push(EV_NOTE, t0 + 27, 2, 2, 4);
      push(EV_RD,   t0 + 35, 'h012, 2, 0);
      push(EV_IDLE, t0 + 37, 0, 0, 1);
      goto_cycle(t0 + 5);
      pause = 1'b1;
      goto_cycle(t0 + 15);
      pause = 1'b0;
      drain("pause", 200);

      // Stop and start together during PLAY, then a clean replay
      do_start(10'h010, t0);
      push(EV_RD,   t0 + 1, 'h010, 0, 0);
      push(EV_NOTE, t0 + 3, 1, 1, 3);
      push(EV_IDLE, t0 + 6, 0, 0, 0);
      goto_cycle(t0 + 5);
      stop = 1'b1;
      start = 1'b1;
      goto_cycle(t0 + 6);
      stop = 1'b0;
      start = 1'b0;
      drain("stop", 100);
      repeat (20) @(posedge clk);
      do_start(10'h010, t0);
      push_basic(t0);
      drain("replay", 200);

      // Rest with zero duration, then octave code 3
      do_start(10'h020, t0);
      push(EV_RD,   t0 + 1,  'h020, 0, 0);
      push(EV_RD,   t0 + 11, 'h021, 1, 0);
      push(EV_NOTE, t0 + 13, 4, 1, 4);
      push(EV_RD,   t0 + 21, 'h022, 2, 0);
      push(EV_IDLE, t0 + 23, 0, 0, 1);
      drain("edge", 200);

      // Top-of-ROM entry ends the song without reading address 0
      do_start(10'h3FF, t0);
      push(EV_RD,   t0 + 1,  'h3FF, 0, 0);
      push(EV_NOTE, t0 + 3,  'h40, 0, 4);
      push(EV_IDLE, t0 + 11, 0, 0, 1);
      drain("wrap", 200);

      // One-cycle reset during PLAY
      do_start(10'h010, t0);
      push(EV_RD,   t0 + 1, 'h010, 0, 0);
      push(EV_NOTE, t0 + 3, 1, 1, 3);
      push(EV_IDLE, t0 + 6, 0, 0, 0);
      goto_cycle(t0 + 5);
      sys_rst_n = 1'b0;
      goto_cycle(t0 + 6);
      sys_rst_n = 1'b1;
      check_zero("reset mid-note");
      drain("reset", 100);

      checks++;
      if (exp_q.size() != 0) begin
         errors++;
         $display("FAIL scoreboard empty: got %0d pending, required 0", exp_q.size());
      end

      $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
      $finish;
   end

endmodule
`default_nettype wire
